// File: rtl/pic_timing_gen.sv
// Picture timing generator: frame-clear pulse, active pixels with X/Y, H/V blanking,
// frame counting and start/stop run control. Every output comes straight from a flop.
module pic_timing_gen #(
    parameter int IMAGE_W   = 192,
    parameter int IMAGE_H   = 108,
    parameter int H_BLANK   = 8,
    parameter int V_BLANK   = 16,
    parameter int FRAME_NUM = 0
) (
    input  logic        InPixClk,
    input  logic        InRstN,
    input  logic        InStart,
    input  logic        InStop,
    output logic        OutPicClr,
    output logic        OutPicDe,
    output logic        OutHsync,
    output logic        OutVsync,
    output logic [15:0] OutPixX,
    output logic [15:0] OutPixY,
    output logic [15:0] OutFrameCnt,
    output logic        OutBusy,
    output logic        OutFrameDone
);

    localparam logic [15:0] X_LAST    = 16'(IMAGE_W - 1);
    localparam logic [15:0] Y_LAST    = 16'(IMAGE_H - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);
    localparam logic [15:0] FRAME_TGT = 16'(FRAME_NUM);
    localparam bit          LIMITED   = (FRAME_NUM != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } pgState;

    pgState      stateReg, stateNext;
    logic [15:0] cntReg, cntNext;
    logic        stopReg, stopNext;
    logic        runEnd;
    logic [15:0] pixXNext, pixYNext, frameCntNext;
    logic        picClrNext, picDeNext, hsyncNext, vsyncNext, busyNext, frameDoneNext;

    always_ff @(posedge InPixClk) begin
        if (!InRstN) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            stopReg      <= 1'b0;
            OutPicClr    <= 1'b0;
            OutPicDe     <= 1'b0;
            OutHsync     <= 1'b0;
            OutVsync     <= 1'b0;
            OutPixX      <= '0;
            OutPixY      <= '0;
            OutFrameCnt  <= '0;
            OutBusy      <= 1'b0;
            OutFrameDone <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            stopReg      <= stopNext;
            OutPicClr    <= picClrNext;
            OutPicDe     <= picDeNext;
            OutHsync     <= hsyncNext;
            OutVsync     <= vsyncNext;
            OutPixX      <= pixXNext;
            OutPixY      <= pixYNext;
            OutFrameCnt  <= frameCntNext;
            OutBusy      <= busyNext;
            OutFrameDone <= frameDoneNext;
        end
    end

    // A stop arriving on the very last VBLANK cycle still ends the run at this boundary.
    assign runEnd = stopReg | InStop | (LIMITED && (OutFrameCnt == FRAME_TGT));

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (InStart) stateNext = CLR;
            CLR:     stateNext = ACTIVE;
            ACTIVE:  if (OutPixX == X_LAST) stateNext = HBLANK;
            HBLANK:  if (cntReg == HB_LAST) stateNext = (OutPixY < Y_LAST) ? ACTIVE : VBLANK;
            VBLANK:  if (cntReg == VB_LAST) stateNext = runEnd ? IDLE : CLR;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        cntNext = (stateNext == stateReg) ? cntReg + 16'd1 : 16'd0;

        stopNext = stopReg | InStop;
        if (stateReg == IDLE) begin
            stopNext = InStart & InStop;
        end else if (stateNext == IDLE) begin
            stopNext = 1'b0;
        end

        // Count becomes visible during the last VBLANK cycle, so the run-end check sees it.
        frameCntNext = OutFrameCnt;
        if (stateReg == IDLE && InStart) begin
            frameCntNext = '0;
        end else if (stateNext == VBLANK && cntNext == VB_LAST) begin
            frameCntNext = OutFrameCnt + 16'd1;
        end

        pixXNext = OutPixX;
        pixYNext = OutPixY;
        if (stateNext == ACTIVE) begin
            pixXNext = (stateReg == ACTIVE) ? OutPixX + 16'd1 : 16'd0;
            if (stateReg == CLR) begin
                pixYNext = 16'd0;
            end else if (stateReg == HBLANK) begin
                pixYNext = OutPixY + 16'd1;
            end
        end

        picClrNext    = (stateNext == CLR);
        picDeNext     = (stateNext == ACTIVE);
        hsyncNext     = (stateNext == HBLANK);
        vsyncNext     = (stateNext == VBLANK);
        busyNext      = (stateNext != IDLE);
        frameDoneNext = (stateReg == VBLANK) && (stateNext == IDLE);
    end

endmodule

// File: tb/tb_pic_timing_gen.sv
// Bench for pic_timing_gen: a continuous-run and a single-frame instance checked every
// cycle against a frame-phase reference model, plus frame period and DE-count checks.
module tb_pic_timing_gen;

    localparam int IW  = 4;
    localparam int IH  = 3;
    localparam int HB  = 2;
    localparam int VB  = 3;
    localparam int LW  = IW + HB;
    localparam int FL  = 1 + IH * LW + VB;
    localparam int FN0 = 0;
    localparam int FN1 = 1;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  start, stop;
    logic [1:0]  picClr, picDe, hsync, vsync, busy, done;
    logic [15:0] pixX [2];
    logic [15:0] pixY [2];
    logic [15:0] frameCnt [2];

    always #5 clk = ~clk;

    pic_timing_gen #(.IMAGE_W(IW), .IMAGE_H(IH), .H_BLANK(HB), .V_BLANK(VB), .FRAME_NUM(FN0)) dut0 (
        .InPixClk(clk), .InRstN(rstN), .InStart(start[0]), .InStop(stop[0]),
        .OutPicClr(picClr[0]), .OutPicDe(picDe[0]), .OutHsync(hsync[0]), .OutVsync(vsync[0]),
        .OutPixX(pixX[0]), .OutPixY(pixY[0]), .OutFrameCnt(frameCnt[0]),
        .OutBusy(busy[0]), .OutFrameDone(done[0])
    );

    pic_timing_gen #(.IMAGE_W(IW), .IMAGE_H(IH), .H_BLANK(HB), .V_BLANK(VB), .FRAME_NUM(FN1)) dut1 (
        .InPixClk(clk), .InRstN(rstN), .InStart(start[1]), .InStop(stop[1]),
        .OutPicClr(picClr[1]), .OutPicDe(picDe[1]), .OutHsync(hsync[1]), .OutVsync(vsync[1]),
        .OutPixX(pixX[1]), .OutPixY(pixY[1]), .OutFrameCnt(frameCnt[1]),
        .OutBusy(busy[1]), .OutFrameDone(done[1])
    );

    // Reference model: a run is a sequence of frames, each indexed by phase 0..FL-1.
    bit          mRun  [2];
    int          mP    [2];
    logic [15:0] mFc   [2];
    logic [15:0] mX    [2];
    logic [15:0] mY    [2];
    bit          mStop [2];
    bit          mDone [2];

    int nVec = 0;
    int nMis = 0;
    int cycN = 0;
    int lastClr [2] = '{-1, -1};
    int deCnt   [2] = '{0, 0};

    task automatic modelStep(input int id, input bit r, input bit s, input bit p);
        int fn;
        fn = (id == 0) ? FN0 : FN1;
        if (!r) begin
            mRun[id] = 0; mP[id] = 0; mFc[id] = '0; mX[id] = '0; mY[id] = '0;
            mStop[id] = 0; mDone[id] = 0;
        end else begin
            mDone[id] = 0;
            if (!mRun[id]) begin
                if (s) begin
                    mRun[id] = 1; mP[id] = 0; mFc[id] = '0; mStop[id] = p;
                end
            end else begin
                mStop[id] = mStop[id] | p;
                if (mP[id] == FL - 1) begin
                    if (mStop[id] || (fn != 0 && mFc[id] == 16'(fn))) begin
                        mRun[id] = 0; mDone[id] = 1; mStop[id] = 0;
                    end else begin
                        mP[id] = 0;
                    end
                end else begin
                    mP[id]++;
                end
                if (mRun[id]) begin
                    if (mP[id] >= 1 && mP[id] <= IH * LW && (mP[id] - 1) % LW < IW) begin
                        mX[id] = 16'((mP[id] - 1) % LW);
                        mY[id] = 16'((mP[id] - 1) / LW);
                    end
                    if (mP[id] == FL - 1) mFc[id] = mFc[id] + 16'd1;
                end
            end
        end
    endtask

    function automatic logic [53:0] expVec(input int id);
        bit inLines, clrE, deE, hsE, vsE;
        inLines = mRun[id] && mP[id] >= 1 && mP[id] <= IH * LW;
        clrE = mRun[id] && mP[id] == 0;
        deE  = inLines && ((mP[id] - 1) % LW < IW);
        hsE  = inLines && ((mP[id] - 1) % LW >= IW);
        vsE  = mRun[id] && mP[id] > IH * LW;
        return {clrE, deE, hsE, vsE, mRun[id], mDone[id], mX[id], mY[id], mFc[id]};
    endfunction

    task automatic checkAll();
        logic [53:0] obs, expd;
        for (int id = 0; id < 2; id++) begin
            obs  = {picClr[id], picDe[id], hsync[id], vsync[id], busy[id], done[id],
                    pixX[id], pixY[id], frameCnt[id]};
            expd = expVec(id);
            nVec++;
            assert (obs === expd) else begin
                nMis++;
                $error("FAIL outputs dut%0d cyc %0d: got %h want %h (clr,de,hs,vs,busy,done,x,y,cnt)",
                       id, cycN, obs, expd);
            end
            nVec++;
            assert ($onehot0({picClr[id], picDe[id], hsync[id], vsync[id]})) else begin
                nMis++;
                $error("FAIL exclusive dut%0d cyc %0d: got %b want at most one set",
                       id, cycN, {picClr[id], picDe[id], hsync[id], vsync[id]});
            end
            if (picClr[id]) begin
                if (lastClr[id] >= 0) begin
                    nVec++;
                    assert (cycN - lastClr[id] == FL) else begin
                        nMis++;
                        $error("FAIL period dut%0d cyc %0d: got %0d want %0d", id, cycN, cycN - lastClr[id], FL);
                    end
                    nVec++;
                    assert (deCnt[id] == IW * IH) else begin
                        nMis++;
                        $error("FAIL decount dut%0d cyc %0d: got %0d want %0d", id, cycN, deCnt[id], IW * IH);
                    end
                end
                lastClr[id] = cycN;
                deCnt[id] = 0;
            end
            if (picDe[id]) deCnt[id]++;
            if (done[id]) begin
                nVec++;
                assert (deCnt[id] == IW * IH) else begin
                    nMis++;
                    $error("FAIL lastframe_de dut%0d cyc %0d: got %0d want %0d", id, cycN, deCnt[id], IW * IH);
                end
                lastClr[id] = -1;
            end
        end
    endtask

    task automatic cyc(input bit r, input logic [1:0] s, input logic [1:0] p);
        rstN = r; start = s; stop = p;
        @(posedge clk);
        for (int id = 0; id < 2; id++) modelStep(id, r, s[id], p[id]);
        if (!r) begin
            lastClr = '{-1, -1};
            deCnt = '{0, 0};
        end
        #1;
        cycN++;
        checkAll();
    endtask

    initial begin
        rstN = 1'b0; start = 2'b00; stop = 2'b00;
        @(negedge clk);

        // Reset state
        repeat (3) cyc(1'b0, 2'b00, 2'b00);

        // Start both: dut1 yields one frame, dut0 runs continuously
        cyc(1'b1, 2'b11, 2'b00);
        repeat (70) cyc(1'b1, 2'b00, 2'b00);

        // Start pulses while dut0 is busy are ignored
        for (int i = 0; i < 12; i++) cyc(1'b1, (i % 3 == 0) ? 2'b01 : 2'b00, 2'b00);

        // Stop the continuous run, then a new run stopped during line 1
        cyc(1'b1, 2'b00, 2'b01);
        repeat (30) cyc(1'b1, 2'b00, 2'b00);
        cyc(1'b1, 2'b01, 2'b00);
        repeat (8) cyc(1'b1, 2'b00, 2'b00);
        cyc(1'b1, 2'b00, 2'b01);
        repeat (30) cyc(1'b1, 2'b00, 2'b00);

        // Stop in IDLE is ignored; reset during HBLANK of line 0
        cyc(1'b1, 2'b00, 2'b11);
        cyc(1'b1, 2'b11, 2'b00);
        repeat (5) cyc(1'b1, 2'b00, 2'b00);
        cyc(1'b0, 2'b00, 2'b00);
        repeat (3) cyc(1'b1, 2'b00, 2'b00);
        cyc(1'b1, 2'b11, 2'b00);
        repeat (25) cyc(1'b1, 2'b00, 2'b00);

        // Start and stop together in IDLE, with extra starts while busy
        cyc(1'b0, 2'b00, 2'b00);
        cyc(1'b1, 2'b11, 2'b11);
        for (int i = 0; i < 26; i++) cyc(1'b1, (i % 4 == 1) ? 2'b11 : 2'b00, 2'b00);
        repeat (30) cyc(1'b1, 2'b00, 2'b00);

        // Randomised control traffic
        repeat (600) begin
            cyc($urandom_range(0, 299) != 0,
                {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
                {$urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/pic_timing_gen.md
PIC_TIMING_GEN -- requirements
Module: pic_timing_gen

Interface
REQ-001 Parameter IMAGE_W, default 192, active pixels per line; SHALL be >= 2.
REQ-002 Parameter IMAGE_H, default 108, active lines per frame; SHALL be >= 1.
REQ-003 Parameter H_BLANK, default 8, blanking cycles after each line; SHALL be >= 1.
REQ-004 Parameter V_BLANK, default 16, blanking cycles after the last line's H_BLANK; SHALL be >= 1.
REQ-005 Parameter FRAME_NUM, default 0, frames per run; 0 means continuous.
REQ-006 InPixClk  input  1  pixel clock; all logic on its rising edge.
REQ-007 InRstN  input  1  reset; synchronous, active-low.
REQ-008 InStart  input  1  start request; honoured only in IDLE.
REQ-009 InStop  input  1  stop request; latched, takes effect at the next frame boundary.
REQ-010 OutPicClr  output  1  one-cycle frame-start pulse, drives a sink's frame-clear input.
REQ-011 OutPicDe  output  1  active-pixel enable.
REQ-012 OutHsync  output  1  high during H_BLANK cycles.
REQ-013 OutVsync  output  1  high during V_BLANK cycles.
REQ-014 OutPixX  output  16  column of the current DE cycle, 0..IMAGE_W-1.
REQ-015 OutPixY  output  16  line of the current DE cycle, 0..IMAGE_H-1.
REQ-016 OutFrameCnt  output  16  completed frames since start, wraps at 65535 -> 0.
REQ-017 OutBusy  output  1  high in every state except IDLE.
REQ-018 OutFrameDone  output  1  one-cycle pulse when a run ends and the block returns to IDLE.

Function
REQ-019 All outputs SHALL be registered, with no combinational path from input to output.
REQ-020 The FSM SHALL have the states IDLE, CLR, ACTIVE, HBLANK and VBLANK.
REQ-021 IDLE: on InStart=1 at edge k, the FSM SHALL go to CLR, giving OutPicClr=1 in cycle k+1 only; OutFrameCnt and the stop latch SHALL clear on that same edge.
REQ-022 CLR SHALL last 1 cycle, then go to ACTIVE with OutPixX=0 and OutPixY=0.
REQ-023 ACTIVE SHALL last IMAGE_W cycles with OutPicDe=1 and OutPixX incrementing by 1 per cycle; it SHALL then go to HBLANK.
REQ-024 HBLANK SHALL last H_BLANK cycles with OutHsync=1.
REQ-025 At the end of HBLANK, if OutPixY < IMAGE_H-1, the FSM SHALL go to ACTIVE with OutPixY+1 and OutPixX=0; otherwise it SHALL go to VBLANK.
REQ-026 VBLANK SHALL last V_BLANK cycles with OutVsync=1; on its last cycle OutFrameCnt SHALL increment.
REQ-027 After VBLANK the FSM SHALL go to IDLE with OutFrameDone=1 for 1 cycle if the stop latch is set, or if FRAME_NUM!=0 and frames completed == FRAME_NUM; otherwise it SHALL go to CLR.
REQ-028 Frame length SHALL be exactly 1 + IMAGE_H*(IMAGE_W+H_BLANK) + V_BLANK cycles, with IMAGE_W*IMAGE_H DE cycles.
REQ-029 InStop=1 in any non-IDLE state SHALL set the stop latch; the current frame SHALL always complete in full.
REQ-030 InStart while busy SHALL be ignored, and InStop in IDLE SHALL be ignored.
REQ-031 InStart and InStop high together in IDLE SHALL start a run and latch stop, producing exactly one frame.
REQ-032 OutPicDe, OutHsync, OutVsync and OutPicClr SHALL be mutually exclusive in every cycle.
REQ-033 OutPixX and OutPixY SHALL hold their last value outside ACTIVE.
REQ-034 An internal cycle counter SHALL be 16 bits wide; IMAGE_W, H_BLANK and V_BLANK SHALL each be < 65536.

Reset
REQ-035 When InRstN=0 at a clock edge, on that edge the FSM SHALL enter IDLE.
REQ-036 On that same edge all outputs and counters SHALL go to 0 and the stop latch SHALL clear.
REQ-037 Reset SHALL take precedence over all inputs, including mid-frame; no partial pulse SHALL follow it.
REQ-038 After reset is released, the block SHALL start only on a new InStart.

Verification (IMAGE_W=4, IMAGE_H=3, H_BLANK=2, V_BLANK=3 unless stated)
REQ-039 FRAME_NUM=1, InStart pulse at cycle 0 -> expected response:
- OutPicClr at cycle 1.
- DE cycles 2-5, 8-11 and 14-17.
- Hsync cycles 6-7, 12-13 and 18-19.
- Vsync cycles 20-22.
- OutFrameDone at cycle 23, OutFrameCnt=1, 12 DE cycles total.
REQ-040 FRAME_NUM=0, run for 3 frames -> expected response:
- OutPicClr every 22 cycles.
- OutFrameCnt steps 1, 2, 3.
- OutBusy stays high throughout.
- OutPixX/OutPixY sequence (0,0)..(3,2) repeats per frame.
REQ-041 FRAME_NUM=0, InStop pulse during line 1 of frame 0 -> expected response:
- Frame 0 completes with 12 DE cycles.
- OutFrameDone fires.
- No further OutPicClr.
REQ-042 InRstN=0 for 1 cycle during HBLANK -> expected response:
- All outputs are 0 on the next cycle.
- The FSM is in IDLE.
- A subsequent InStart gives a complete frame.
REQ-043 Extra InStart pulses while busy plus simultaneous InStart/InStop in IDLE -> expected response:
- The extra InStart pulses are ignored.
- Exactly one frame is produced per accepted start.
REQ-044 Every cycle of every scenario -> expected response:
- Assert the exclusivity rule of REQ-032.
- Assert the 22-cycle frame period of REQ-028.
